// File: rtl/spi_master_pkg.sv
// spi_master_pkg: shared state encoding and frame geometry for the 24-bit SPI master
package spi_master_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_SETUP, ST_SCK_HI, ST_SCK_LO, ST_HOLD, ST_DONE} state_t;
  localparam int FRAME_BITS = 24;
  localparam int ADDR_BITS = 8;
  localparam int DATA_BITS = 16;
  localparam int RDATA_FIRST_BIT = 8;
endpackage

// File: rtl/spi_master_24bit_clk_div.sv
// spi_clk_div: loadable down-counter giving a one-cycle tick after load_val enabled cycles
module spi_clk_div
  import spi_master_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] load_val,
  output logic         tick
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  end
  assign tick = en && cnt == W'(1);
endmodule

// File: rtl/spi_master_24bit.sv
// spi_master_24bit: mode-0 SPI master sending {addr, wdata} MSB first and capturing 16 readback bits
module spi_master_24bit
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  addr,
  input  logic [15:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [15:0] rdata,
  output logic        cs,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);
  state_t state;
  logic [4:0] bit_cnt;
  logic [FRAME_BITS-1:0] sh;
  logic [DATA_BITS-1:0] rx;
  logic en, load, tick, last;
  logic [7:0] load_val;
  always_comb begin
    en = state inside {ST_SETUP, ST_SCK_HI, ST_SCK_LO, ST_HOLD};
    last = bit_cnt == 5'(FRAME_BITS - 1);
    load = (state == ST_IDLE && start) || (tick && state != ST_HOLD);
    load_val = state == ST_IDLE ? 8'(CS_SETUP) : (state == ST_SCK_LO && last) ? 8'(CS_HOLD) : 8'(CLK_DIV);
  end
  spi_clk_div #(.W(8)) u_div (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .clear(state == ST_DONE),
    .load_val(load_val), .tick(tick)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cs <= 1'b1;
      sclk <= 1'b0;
      mosi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      rdata <= '0;
      bit_cnt <= '0;
      sh <= '0;
      rx <= '0;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          state <= ST_SETUP;
          cs <= 1'b0;
          busy <= 1'b1;
          sh <= {addr, wdata};
          mosi <= addr[ADDR_BITS-1];
          bit_cnt <= '0;
        end
        ST_SETUP: if (tick) begin
          state <= ST_SCK_HI;
          sclk <= 1'b1;
        end
        ST_SCK_HI: if (tick) begin
          state <= ST_SCK_LO;
          sclk <= 1'b0;
          mosi <= sh[FRAME_BITS-2];
          sh <= sh << 1;
        end
        ST_SCK_LO: if (tick) begin
          if (last) state <= ST_HOLD;
          else begin
            state <= ST_SCK_HI;
            sclk <= 1'b1;
            bit_cnt <= bit_cnt + 1'b1;
            // the rising edge about to happen is bit bit_cnt+1; keep bits 8..23 only
            if (bit_cnt >= 5'(RDATA_FIRST_BIT - 1)) rx <= {rx[DATA_BITS-2:0], miso};
          end
        end
        ST_HOLD: if (tick) begin
          state <= ST_DONE;
          cs <= 1'b1;
          busy <= 1'b0;
          done <= 1'b1;
          rdata <= rx;
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_master_24bit.sv
// tb_spi_master_24bit: directed frames against a behavioural register slave (mode reg bit0 = read-only)
module tb_spi_master_24bit;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, miso = 1'b0;
  logic [7:0] addr = '0;
  logic [15:0] wdata = '0;
  logic busy, done, cs, sclk, mosi;
  logic [15:0] rdata;
  int vecs = 0, errs = 0;
  logic [15:0] regs [4] = '{default: 16'h0};
  logic [23:0] cap = '0;
  logic [15:0] tx = '0;
  int nrise = 0;
  logic pcs = 1'b1, psclk = 1'b0;

  spi_master_24bit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .addr(addr), .wdata(wdata), .busy(busy),
    .done(done), .rdata(rdata), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  always #5 clk = ~clk;

  // slave: returns reg[addr] on bits 8..23, writes at cs rise unless read-only mode is set
  always @(sclk or cs) begin
    if (cs !== pcs) begin
      if (cs === 1'b0) begin nrise = 0; miso = 1'b0; end
      else if (cs === 1'b1 && nrise == 24 && (cap[23:16] == 8'h00 || !regs[0][0])) regs[cap[17:16]] = cap[15:0];
    end else if (cs === 1'b0 && sclk === 1'b1 && psclk === 1'b0) begin
      cap = {cap[22:0], mosi};
      nrise++;
    end else if (cs === 1'b0 && sclk === 1'b0 && psclk === 1'b1 && nrise >= 8 && nrise < 24) begin
      if (nrise == 8) tx = regs[cap[1:0]];
      miso = tx[15];
      tx = tx << 1;
    end
    pcs = cs;
    psclk = sclk;
  end

  task automatic send(input logic [7:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    addr = a; wdata = d; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; addr = ~a; wdata = ~d;
  endtask

  // starts at E0+1; returns at the done sample (lat = -1 on timeout)
  task automatic watch(input int pulse_at, output int lat, output int csl, output int hiw, output int first_rise, output int rises);
    int run = 0;
    logic prev = 1'b0;
    lat = -1; csl = 0; hiw = 0; first_rise = -1; rises = 0;
    for (int n = 0; n < 400; n++) begin
      if (done) begin lat = n; break; end
      if (!cs) csl++;
      if (sclk) begin
        run++;
        if (!prev) begin rises++; if (first_rise < 0) first_rise = n; end
      end else begin
        if (run > hiw) hiw = run;
        run = 0;
      end
      prev = sclk;
      start = (n == pulse_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vecs++; if ({cs, sclk, busy, done} !== 4'b1000) begin errs++; $display("FAIL reset_ctrl: got cs,sclk,busy,done=%b want 1000", {cs, sclk, busy, done}); end
    vecs++; if (rdata !== 16'h0000) begin errs++; $display("FAIL reset_rdata: got %h want 0000", rdata); end
    rst_n = 1'b1;
  endtask

  task automatic test_write;
    int lat, csl, hiw, fr, rises;
    send(8'h02, 16'h1234);
    vecs++; if ({cs, busy} !== 2'b01) begin errs++; $display("FAIL accept: got cs,busy=%b want 01", {cs, busy}); end
    watch(-1, lat, csl, hiw, fr, rises);
    vecs++; if (lat !== 196) begin errs++; $display("FAIL wr_latency: got %0d want 196", lat); end
    vecs++; if (csl !== 196) begin errs++; $display("FAIL wr_cs_low: got %0d want 196", csl); end
    vecs++; if (hiw !== 4) begin errs++; $display("FAIL wr_high_width: got %0d want 4", hiw); end
    vecs++; if (fr !== 2) begin errs++; $display("FAIL wr_first_rise: got %0d want 2", fr); end
    vecs++; if (rises !== 24) begin errs++; $display("FAIL wr_rises: got %0d want 24", rises); end
    vecs++; if (cap !== 24'h021234) begin errs++; $display("FAIL wr_mosi: got %h want 021234", cap); end
    vecs++; if ({cs, busy} !== 2'b10) begin errs++; $display("FAIL wr_end: got cs,busy=%b want 10", {cs, busy}); end
    @(posedge clk); #1;
    vecs++; if ({done, cs} !== 2'b01) begin errs++; $display("FAIL wr_done_pulse: got done,cs=%b want 01", {done, cs}); end
  endtask

  task automatic test_read;
    int lat, csl, hiw, fr, rises;
    send(8'h01, 16'hBEEF);
    watch(-1, lat, csl, hiw, fr, rises);
    send(8'h01, 16'h0000);
    watch(-1, lat, csl, hiw, fr, rises);
    vecs++; if (lat !== 196) begin errs++; $display("FAIL rd_latency: got %0d want 196", lat); end
    vecs++; if (rdata !== 16'hBEEF) begin errs++; $display("FAIL rd_rdata: got %h want BEEF", rdata); end
  endtask

  task automatic test_ignore_start;
    int lat, csl, hiw, fr, rises, hi = 0;
    send(8'h03, 16'hA5C3);
    watch(85, lat, csl, hiw, fr, rises);
    vecs++; if (lat !== 196 || csl !== 196 || rises !== 24) begin errs++; $display("FAIL ign_frame: got lat=%0d cs_low=%0d rises=%0d want 196/196/24", lat, csl, rises); end
    vecs++; if (cap !== 24'h03A5C3) begin errs++; $display("FAIL ign_mosi: got %h want 03A5C3", cap); end
    addr = 8'h03; wdata = 16'h0F0F; start = 1'b1;
    while (cs && hi < 10) begin hi++; @(posedge clk); #1; end
    start = 1'b0; addr = 8'hFF; wdata = 16'hFFFF;
    vecs++; if (hi !== 2) begin errs++; $display("FAIL gap_cs_high: got %0d want 2", hi); end
    watch(-1, lat, csl, hiw, fr, rises);
    vecs++; if (lat !== 196) begin errs++; $display("FAIL b2b_latency: got %0d want 196", lat); end
    vecs++; if (rdata !== 16'hA5C3) begin errs++; $display("FAIL b2b_rdata: got %h want A5C3", rdata); end
    vecs++; if (cap !== 24'h030F0F) begin errs++; $display("FAIL b2b_mosi: got %h want 030F0F", cap); end
  endtask

  task automatic test_abort;
    int lat, csl, hiw, fr, rises, bad = 0;
    send(8'h02, 16'hFFFF);
    repeat (85) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    vecs++; if ({cs, sclk, busy, done} !== 4'b1000) begin errs++; $display("FAIL abort_ctrl: got cs,sclk,busy,done=%b want 1000", {cs, sclk, busy, done}); end
    vecs++; if (rdata !== 16'h0000) begin errs++; $display("FAIL abort_rdata: got %h want 0000", rdata); end
    repeat (20) begin @(posedge clk); #1; if (done || !cs) bad++; end
    vecs++; if (bad !== 0) begin errs++; $display("FAIL abort_quiet: got %0d active cycles want 0", bad); end
    send(8'h02, 16'h3C3C);
    watch(-1, lat, csl, hiw, fr, rises);
    vecs++; if (lat !== 196 || rises !== 24) begin errs++; $display("FAIL post_abort: got lat=%0d rises=%0d want 196/24", lat, rises); end
    vecs++; if (cap !== 24'h023C3C) begin errs++; $display("FAIL post_abort_mosi: got %h want 023C3C", cap); end
    vecs++; if (rdata !== 16'h1234) begin errs++; $display("FAIL post_abort_rdata: got %h want 1234", rdata); end
  endtask

  task automatic test_integration;
    int lat, csl, hiw, fr, rises;
    logic [7:0] a [5] = '{8'h00, 8'h02, 8'h00, 8'h02, 8'h02};
    logic [15:0] d [5] = '{16'h0000, 16'h5A5A, 16'h0001, 16'h0000, 16'h0000};
    logic [15:0] exp [5] = '{16'h0000, 16'h3C3C, 16'h0000, 16'h5A5A, 16'h5A5A};
    for (int i = 0; i < 5; i++) begin
      send(a[i], d[i]);
      watch(-1, lat, csl, hiw, fr, rises);
      vecs++; if (lat !== 196 || rdata !== exp[i]) begin errs++; $display("FAIL integ_%0d: got lat=%0d rdata=%h want 196/%h", i, lat, rdata, exp[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_abort();
    test_integration();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
